// File: rtl/switch_debounce_pkg.sv
// -----------------------------------------------------------------------------
// switch_debounce_pkg
// Shared lamp-project constants: debounce counter width and hold time, used by
// the switch debouncer and the lamp timer, plus the level type and the parity
// helper for the debounced switch vector.
// No ports (package).
// -----------------------------------------------------------------------------
package switch_debounce_pkg;

  // Default debounce counter width and hold time (cycles)
  localparam int SWDB_DB_BITS = 32'd20;
  localparam int SWDB_DB_MAX  = 32'h000F_FFFF;

  // Number of switch channels handled by the debouncer
  localparam int SWDB_NUM_CH  = 32'd3;

  // Debounced level vector, bit i = channel i ({S3,S2,S1})
  typedef logic [SWDB_NUM_CH-1:0] swdb_lvl_t;

  // Even-parity bit of the debounced levels
  function automatic logic swdb_parity(input swdb_lvl_t lvl);
    return ^lvl;
  endfunction

endpackage

// File: rtl/switch_debounce_sw_db_chan.sv
// -----------------------------------------------------------------------------
// sw_db_chan
// One switch channel: 2-flop synchronizer, debounce counter and stable bit.
// A differing synced level must persist DB_MAX consecutive cycles before the
// stable bit follows it; any agreement cycle clears the counter.
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   i_pin          in   raw asynchronous switch pin
//   i_prime        in   priming window: stable tracks the synced level directly
//   o_stable       out  debounced level (register)
//   o_stable_next  out  value the stable bit takes on the next edge
// -----------------------------------------------------------------------------
module sw_db_chan
  import switch_debounce_pkg::*;
#(
  parameter int DB_BITS = SWDB_DB_BITS,
  parameter int DB_MAX  = SWDB_DB_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  input  logic i_prime,
  output logic o_stable,
  output logic o_stable_next
);

  localparam logic [DB_BITS-1:0] LP_CNT_ZERO = '0;
  localparam logic [DB_BITS-1:0] LP_CNT_ONE  = DB_BITS'(32'd1);
  // Counter value on the last differing cycle before acceptance
  localparam logic [DB_BITS-1:0] LP_CNT_LAST = DB_BITS'(DB_MAX - 32'd1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic [DB_BITS-1:0] r_cnt;
  logic               w_stable_next;
  logic [DB_BITS-1:0] w_cnt_next;

  // Two-flop synchronizer for the raw pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce decision; the counter tops out at LP_CNT_LAST so it cannot wrap
  always_comb begin
    w_stable_next = r_stable;
    w_cnt_next    = r_cnt;
    if (i_prime) begin
      w_stable_next = r_sync2;
      w_cnt_next    = LP_CNT_ZERO;
    end else if (r_sync2 == r_stable) begin
      w_stable_next = r_stable;
      w_cnt_next    = LP_CNT_ZERO;
    end else if (r_cnt == LP_CNT_LAST) begin
      w_stable_next = r_sync2;
      w_cnt_next    = LP_CNT_ZERO;
    end else begin
      w_stable_next = r_stable;
      w_cnt_next    = r_cnt + LP_CNT_ONE;
    end
  end

  // Stable bit and debounce counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= 1'b0;
      r_cnt    <= LP_CNT_ZERO;
    end else begin
      r_stable <= w_stable_next;
      r_cnt    <= w_cnt_next;
    end
  end

  assign o_stable      = r_stable;
  assign o_stable_next = w_stable_next;

endmodule

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Debounces three bouncing switch pins. SW comes straight from the channel
// stable registers; P is registered from the channels' next-stable values so
// it changes on the same edge as SW; T pulses for one cycle the cycle after
// SW changes and restarts the downstream lamp timer.
// For DB_MAX cycles after reset release the channels are primed (stable bits
// follow the synced pins) and T is suppressed.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   S1,S2,S3   in   raw asynchronous switch pins
//   SW[2:0]    out  debounced levels {S3,S2,S1}
//   P          out  parity of SW
//   T          out  one-cycle pulse after any change of SW
// -----------------------------------------------------------------------------
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int DB_BITS = SWDB_DB_BITS,
  parameter int DB_MAX  = SWDB_DB_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  output logic [2:0] SW,
  output logic       P,
  output logic       T
);

  localparam logic [DB_BITS-1:0] LP_PRIME_ZERO = '0;
  localparam logic [DB_BITS-1:0] LP_PRIME_ONE  = DB_BITS'(32'd1);
  localparam logic [DB_BITS-1:0] LP_PRIME_END  = DB_BITS'(DB_MAX);

  logic [DB_BITS-1:0] r_prime_cnt;
  logic               w_prime;
  swdb_lvl_t          w_pins;
  swdb_lvl_t          w_stable;
  swdb_lvl_t          w_stable_next;
  swdb_lvl_t          r_sw_prev;
  swdb_lvl_t          w_sw_prev_next;
  logic               w_chg;
  logic               r_p;
  logic               r_t;

  assign w_pins = {S3, S2, S1};

  genvar gi;
  generate
    for (gi = 0; gi < SWDB_NUM_CH; gi++) begin : g_ch
      sw_db_chan #(
        .DB_BITS (DB_BITS),
        .DB_MAX  (DB_MAX)
      ) u_chan (
        .clk           (clk),
        .rst           (rst),
        .i_pin         (w_pins[gi]),
        .i_prime       (w_prime),
        .o_stable      (w_stable[gi]),
        .o_stable_next (w_stable_next[gi])
      );
    end
  endgenerate

  assign w_prime = (r_prime_cnt != LP_PRIME_END);

  // Priming counter: counts the first DB_MAX cycles after reset, then holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prime_cnt <= LP_PRIME_ZERO;
    end else if (w_prime) begin
      r_prime_cnt <= r_prime_cnt + LP_PRIME_ONE;
    end else begin
      r_prime_cnt <= r_prime_cnt;
    end
  end

  // Change detect: r_sw_prev is SW one cycle late. While priming it is loaded
  // with the value SW is about to take, so priming-time changes (including one
  // on the last priming edge) never look like a change afterwards.
  always_comb begin
    w_sw_prev_next = w_stable;
    w_chg          = 1'b0;
    if (w_prime) begin
      w_sw_prev_next = w_stable_next;
      w_chg          = 1'b0;
    end else begin
      w_sw_prev_next = w_stable;
      w_chg          = (w_stable != r_sw_prev);
    end
  end

  // Output registers for parity and toggle strobe, plus the SW history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_prev <= '0;
      r_p       <= 1'b0;
      r_t       <= 1'b0;
    end else begin
      r_sw_prev <= w_sw_prev_next;
      r_p       <= swdb_parity(w_stable_next);
      r_t       <= w_chg;
    end
  end

  assign SW = w_stable;
  assign P  = r_p;
  assign T  = r_t;

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
// Directed bench for switch_debounce with DB_BITS=3, DB_MAX=4. Inputs are
// driven and outputs sampled on the falling clock edge. A clean step applied
// at a falling edge shows on SW/P at the 6th falling edge after it and T at
// the 7th.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

  logic       clk;
  logic       rst;
  logic       s1;
  logic       s2;
  logic       s3;
  logic [2:0] sw;
  logic       p;
  logic       t;

  int n_tests;
  int n_fail;

  switch_debounce #(
    .DB_BITS (3),
    .DB_MAX  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .S1  (s1),
    .S2  (s2),
    .S3  (s3),
    .SW  (sw),
    .P   (p),
    .T   (t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    s1  = 1'b0;
    s2  = 1'b0;
    s3  = 1'b0;

    // Reset state
    tick(2);
    check_val("rst_sw", 8'(sw), 8'h0);
    check_val("rst_p",  8'(p),  8'h0);
    check_val("rst_t",  8'(t),  8'h0);

    // Idle with all pins low: no toggle, levels stay zero
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_val("idle_t", 8'(t), 8'h0);
    end
    check_val("idle_sw", 8'(sw), 8'h0);
    check_val("idle_p",  8'(p),  8'h0);

    // Clean S1 step: SW/P at +6, T at +7 only
    s1 = 1'b1;
    tick(5);
    check_val("s1_pre_sw", 8'(sw), 8'h0);
    tick(1);
    check_val("s1_sw",    8'(sw), 8'h1);
    check_val("s1_p",     8'(p),  8'h1);
    check_val("s1_t_pre", 8'(t),  8'h0);
    tick(1);
    check_val("s1_t",     8'(t),  8'h1);
    tick(1);
    check_val("s1_t_end", 8'(t),  8'h0);

    // S2 glitch of 3 cycles is rejected
    s2 = 1'b1;
    tick(3);
    s2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_val("glitch_sw", 8'(sw), 8'h1);
      check_val("glitch_p",  8'(p),  8'h1);
      check_val("glitch_t",  8'(t),  8'h0);
    end

    // Return S1 low
    s1 = 1'b0;
    tick(8);
    check_val("s1_low_sw", 8'(sw), 8'h0);
    check_val("s1_low_p",  8'(p),  8'h0);

    // S1 and S3 together: SW=101, P=0, a single T pulse
    s1 = 1'b1;
    s3 = 1'b1;
    tick(5);
    check_val("s13_pre_sw", 8'(sw), 8'h0);
    tick(1);
    check_val("s13_sw",    8'(sw), 8'h5);
    check_val("s13_p",     8'(p),  8'h0);
    check_val("s13_t_pre", 8'(t),  8'h0);
    tick(1);
    check_val("s13_t",     8'(t),  8'h1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_val("s13_t_after", 8'(t), 8'h0);
    end

    // Reset two cycles into an S2 count
    s2 = 1'b1;
    tick(4);
    check_val("mid_pre_sw", 8'(sw), 8'h5);
    #2;
    rst = 1'b1;
    s1  = 1'b0;
    s3  = 1'b0;
    #1;
    check_val("async_sw", 8'(sw), 8'h0);
    check_val("async_p",  8'(p),  8'h0);
    check_val("async_t",  8'(t),  8'h0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_val("prime_t", 8'(t), 8'h0);
    end
    check_val("prime_sw", 8'(sw), 8'h2);
    check_val("prime_p",  8'(p),  8'h1);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check_val("post_prime_t",  8'(t),  8'h0);
      check_val("post_prime_sw", 8'(sw), 8'h2);
    end

    // S1 accepted in cycle n, S2 release accepted in n+1
    s1 = 1'b1;
    tick(1);
    s2 = 1'b0;
    tick(4);
    check_val("cons_pre_sw", 8'(sw), 8'h2);
    tick(1);
    check_val("cons_sw1", 8'(sw), 8'h3);
    check_val("cons_p1",  8'(p),  8'h0);
    check_val("cons_t0",  8'(t),  8'h0);
    tick(1);
    check_val("cons_sw2", 8'(sw), 8'h1);
    check_val("cons_p2",  8'(p),  8'h1);
    check_val("cons_t1",  8'(t),  8'h1);
    tick(1);
    check_val("cons_t2",  8'(t),  8'h1);
    tick(1);
    check_val("cons_t3",  8'(t),  8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter DB_BITS, default 20: debounce counter width.
REQ-002 Parameter DB_MAX, default 20'hF_FFFF: consecutive cycles a changed input must hold before acceptance (1 <= DB_MAX <= 2^DB_BITS-1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 S1, S2, S3  input  1 each  raw, asynchronous, bouncing switch pins.
REQ-006 SW  output  3  debounced switch levels {S3,S2,S1}, registered.
REQ-007 P  output  1  parity of SW (SW[0]^SW[1]^SW[2]), registered.
REQ-008 T  output  1  one-cycle toggle pulse when any debounced level changes; this is the restart strobe for the lamp timer downstream.

Function
REQ-009 Each pin SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each channel SHALL hold a stable bit and a DB_BITS counter.
REQ-011 If synced value equals stable, the counter SHALL clear to 0 that cycle.
REQ-012 If synced value differs from stable, the counter SHALL increment.
REQ-013 When the counter equals DB_MAX-1 and synced still differs, stable SHALL take the synced value on that edge and the counter SHALL clear; net acceptance requires DB_MAX consecutive differing cycles.
REQ-014 A single cycle of agreement with stable during counting SHALL clear the counter (glitch rejected); the counter SHALL never wrap.
REQ-015 Pin-to-SW latency SHALL be exactly 2 + DB_MAX cycles for a clean step.
REQ-016 P SHALL update in the same cycle as SW (combined in the same register stage).
REQ-017 T SHALL be 1 for exactly one cycle, in the cycle after SW changes, for any nonzero change.
REQ-018 Simultaneous acceptance on 2 or 3 channels in the same cycle SHALL produce a single one-cycle T.
REQ-019 Acceptances on different channels in consecutive cycles SHALL produce T high in each of those cycles.
REQ-020 Priming: for the first DB_MAX cycles after reset release, the stable bits SHALL track synced values directly, counters SHALL stay 0, and T SHALL be held 0; normal debouncing starts on the following cycle.
REQ-021 A change of SW at the end of priming SHALL NOT generate T.

Reset
REQ-022 rst asserted SHALL immediately force the following to 0, regardless of clk: synchronizers, stable bits, counters, SW, P, T and the priming counter.
REQ-023 Reset asserted mid-count SHALL discard the pending change.
REQ-024 After release, priming (REQ-020) SHALL restart from zero.

Structure
REQ-025 DB_BITS and DB_MAX defaults SHALL live in the shared lamp-project constants include file, shared with the lamp timer.
REQ-026 The per-channel synchronizer, counter and stable bit SHALL be one sub-module, sw_db_chan, instantiated three times.
REQ-027 The top level SHALL contain only the priming counter, the change detect, and the registers for P and T.

Verification (DB_BITS=3, DB_MAX=4)
REQ-028 Reset with S=000, then hold 000 for 20 cycles -> SW=000, P=0, T never 1.
REQ-029 After priming, step S1 0->1 clean -> SW=001 and P=1 exactly 6 cycles after the step, and T=1 for one cycle on the following cycle.
REQ-030 S2 pulses high for 3 cycles, then returns low -> SW, P and T unchanged.
REQ-031 S1 and S3 step high on the same edge from SW=000 -> SW=101, P=0, and exactly one T pulse.
REQ-032 rst asserted 2 cycles into an S2 count -> all outputs 0 at once; after release, with S2 held 1, SW=010 by the end of priming and no T pulse.
REQ-033 Drive S1 and S2 so their acceptances fall in cycles n and n+1 -> T high in cycles n+1 and n+2, and P toggles twice.
